adma_fifo: RTL and testbench
============================

Name: adma_fifo

Overview:
- Synchronous first-word-fall-through data FIFO. It is the responder end of the ADMA transfer engine's FIFO interface.
- It accepts words pushed with fifo_write/data_to_fifo and presents the head word on data_from_fifo, which is consumed with fifo_read.
- It sits between the ADMA transfer engine and the SD data-line serializer. Whichever side is the producer for the current direction drives the write port; the other side drives the read port.
- It provides full/empty and almost-full/almost-empty watermarks, an occupancy count, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 words.
- AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents and error flags.
- fifo_write  input  1  push request.
- data_to_fifo  input  DATA_WIDTH  push data.
- fifo_read  input  1  pop request (consumes the head word).
- data_from_fifo  output  DATA_WIDTH  head word; valid whenever fifo_empty=0.
- fifo_full  output  1  level == 2**ADDR_WIDTH.
- fifo_empty  output  1  level == 0.
- almost_full  output  1  level >= AF_LEVEL.
- almost_empty  output  1  level <= AE_LEVEL.
- level  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  output  1  sticky; set when a push is rejected.
- underflow  output  1  sticky; set when a pop is rejected.

Behaviour:
- Clock/reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values (RESET=1 at a posedge):
  - wr_ptr=0, rd_ptr=0, level=0.
  - fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - data_from_fifo=0 while empty.
  - Storage array is not cleared.
- flush: identical effect to RESET. Pushes and pops in the same cycle are discarded. RESET takes priority over flush.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array.
  - Pointers are ADDR_WIDTH bits and wrap modulo depth, with no special case at wrap.
  - level is a separate ADDR_WIDTH+1-bit counter.
- Read path (first-word-fall-through):
  - data_from_fifo = mem[rd_ptr], combinational from the registered pointer, whenever level>0.
  - Forced to 0 when empty.
- Flags: all are decoded combinationally from registered level, so they are glitch-free relative to CLK.
- Push acceptance:
  - push_ok = fifo_write & (~fifo_full | pop_ok).
  - A simultaneous push and pop on a full FIFO is accepted; level stays at depth.
- Pop acceptance:
  - pop_ok = fifo_read & ~fifo_empty.
  - A pop on an empty FIFO is always rejected, even with a simultaneous push; there is no bypass.
- Update per posedge (no RESET, no flush):
  - If push_ok: mem[wr_ptr] <= data_to_fifo, wr_ptr++.
  - If pop_ok: rd_ptr++.
  - level <= level + push_ok - pop_ok.
- Errors:
  - fifo_write & ~push_ok sets overflow; the data is dropped and no state changes.
  - fifo_read & ~pop_ok sets underflow; pointers are unchanged.
  - Both flags hold until RESET or flush.
- Latency:
  - A word pushed at edge N appears on data_from_fifo after edge N, if the FIFO was empty.
  - fifo_empty deasserts after edge N.
  - Write-to-read latency is 1 cycle.
- Control state machine (drives flag-set logic; one-hot, 3 states):
  - EMPTY (level==0), PARTIAL (0<level<depth), FULL (level==depth).
  - Transitions:
    - EMPTY->PARTIAL on push_ok.
    - PARTIAL->EMPTY on pop_ok & ~push_ok & level==1.
    - PARTIAL->FULL on push_ok & ~pop_ok & level==depth-1.
    - FULL->PARTIAL on pop_ok & ~push_ok.
    - Any state->EMPTY on RESET or flush.
    - Illegal encoding->EMPTY.
  - The state must always agree with level; the bench checks this.
- Reset mid-operation: in-flight push and pop are discarded; outputs take reset values after that edge.

Test Plan:
1. RESET=1 for 2 cycles, then idle.
   -> fifo_empty=1, level=0, almost_empty=1, overflow=underflow=0, data_from_fifo=0.
2. Push 0xA0000000..0xA000000F (16 words), one per cycle.
   -> level counts 1..16; almost_full rises on the 12th push; fifo_full=1 after the 16th; data_from_fifo=0xA0000000 throughout.
   -> A 17th push sets overflow=1 and level stays 16.
3. From full, pop 16 times.
   -> data_from_fifo sequence 0xA0000000..0xA000000F; fifo_empty=1 after the last pop.
   -> A further pop sets underflow=1, and rd_ptr is unchanged.
4. Simultaneous push and pop at level=16 with data 0xBEEF0001.
   -> level stays 16, overflow stays 0; after 16 further pops that word emerges last.
5. Simultaneous push 0x12345678 and pop at level=0.
   -> Push accepted, pop rejected: level=1, underflow=1, data_from_fifo=0x12345678 next cycle.
6. Wrap and flush.
   -> Push 10, pop 10, push 10: pointers wrap past 15; data is returned in order.
   -> Assert flush together with push: level=0, the flags clear, and the pushed word is discarded.

Source files
------------

// File: rtl/adma_fifo.sv
// rtl/adma_fifo.sv - first-word-fall-through data FIFO between ADMA engine and SD data serializer
module adma_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  fifo_write,
  input  logic [DATA_WIDTH-1:0] data_to_fifo,
  input  logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] data_from_fifo,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // One-hot occupancy class; always tracks level_q.
  typedef enum logic [2:0] {
    ST_EMPTY   = 3'b001,
    ST_PARTIAL = 3'b010,
    ST_FULL    = 3'b100
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  state_t                state_q, state_d;
  logic                  push_ok, pop_ok;

  // Flags decode from the registered level only, so they never glitch mid-cycle.
  always_comb begin
    level          = level_q;
    fifo_empty     = (level_q == '0);
    fifo_full      = (level_q == LVL_FULL);
    almost_full    = (level_q >= LVL_AF);
    almost_empty   = (level_q <= LVL_AE);
    overflow       = overflow_q;
    underflow      = underflow_q;
    data_from_fifo = fifo_empty ? '0 : mem_q[rd_ptr_q];
    // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside a pop.
    pop_ok         = fifo_read & ~fifo_empty;
    push_ok        = fifo_write & (~fifo_full | pop_ok);
  end

  // Next pointer, level and sticky-error values; flush clears everything and drops this cycle's traffic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok) level_d = level_q + LVL_ONE;
      if (pop_ok && !push_ok) level_d = level_q - LVL_ONE;
      if (fifo_write && !push_ok) overflow_d  = 1'b1;
      if (fifo_read && !pop_ok)   underflow_d = 1'b1;
    end
  end

  // Occupancy state machine next-state; unknown encodings recover to empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:   if (push_ok) state_d = ST_PARTIAL;
      ST_PARTIAL: begin
        if (pop_ok && !push_ok && level_q == LVL_ONE)
          state_d = ST_EMPTY;
        else if (push_ok && !pop_ok && level_q == LVL_FULL - LVL_ONE)
          state_d = ST_FULL;
      end
      ST_FULL:    if (pop_ok && !push_ok) state_d = ST_PARTIAL;
      default:    state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  // Storage write; contents are left untouched by reset and flush.
  always_ff @(posedge CLK) begin
    if (!RESET && !flush && push_ok) mem_q[wr_ptr_q] <= data_to_fifo;
  end

endmodule

// File: tb/tb_adma_fifo.sv
// tb/tb_adma_fifo.sv - randomized and directed self-checking bench for adma_fifo
module tb_adma_fifo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        flush;
  logic        fifo_write;
  logic [31:0] data_to_fifo;
  logic        fifo_read;
  logic [31:0] data_from_fifo;
  logic        fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0]  level;
  logic        overflow, underflow;

  adma_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .fifo_write(fifo_write), .data_to_fifo(data_to_fifo),
    .fifo_read(fifo_read), .data_from_fifo(data_from_fifo),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue, pointers as pop/push counts modulo 16.
  logic [31:0] m_q [$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  int          m_wr = 0, m_rd = 0;
  logic        chk_en = 1'b0;
  logic [31:0] obs_dout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic fl, input logic wr,
                            input logic [31:0] din, input logic rd);
    bit pop_ok, push_ok;
    if (rst || fl) begin
      m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_wr = 0; m_rd = 0;
    end else begin
      pop_ok  = rd && (m_q.size() > 0);
      push_ok = wr && (m_q.size() < 16 || pop_ok);
      if (wr && !push_ok) m_ovf = 1'b1;
      if (rd && !pop_ok)  m_unf = 1'b1;
      if (pop_ok)  begin void'(m_q.pop_front()); m_rd = (m_rd + 1) % 16; end
      if (push_ok) begin m_q.push_back(din);     m_wr = (m_wr + 1) % 16; end
    end
  endtask

  // Single compare process: every cycle, between edges, DUT must match the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      int n;
      logic [2:0] st, st_exp;
      n = m_q.size();
      st = dut.state_q;
      st_exp = (n == 0) ? 3'b001 : (n == 16) ? 3'b100 : 3'b010;
      chk("level", 64'(level), 64'(n));
      chk("empty", 64'(fifo_empty), 64'(n == 0));
      chk("full", 64'(fifo_full), 64'(n == 16));
      chk("almost_full", 64'(almost_full), 64'(n >= 12));
      chk("almost_empty", 64'(almost_empty), 64'(n <= 4));
      chk("dout", 64'(data_from_fifo), 64'((n > 0) ? m_q[0] : 32'h0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
      chk("state", 64'(st), 64'(st_exp));
      chk("rd_ptr", 64'(dut.rd_ptr_q), 64'(m_rd));
      chk("wr_ptr", 64'(dut.wr_ptr_q), 64'(m_wr));
    end
  end

  // One clock of stimulus: drive now (just after an edge), sample head at negedge, step model at the edge.
  task automatic cycle(input logic rst, input logic fl, input logic wr,
                       input logic [31:0] din, input logic rd);
    RESET = rst; flush = fl; fifo_write = wr; data_to_fifo = din; fifo_read = rd;
    @(negedge CLK);
    obs_dout = data_from_fifo;
    @(posedge CLK);
    model_step(rst, fl, wr, din, rd);
    #1;
    RESET = 1'b0; flush = 1'b0; fifo_write = 1'b0; fifo_read = 1'b0;
  endtask

  initial begin
    int pw, pr;
    RESET = 1'b1; flush = 1'b0; fifo_write = 1'b0; data_to_fifo = '0; fifo_read = 1'b0;
    @(posedge CLK); #1;

    // 1: reset then idle
    cycle(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t1_empty", 64'(fifo_empty), 64'(1));
    chk("t1_level", 64'(level), 64'(0));
    chk("t1_dout", 64'(data_from_fifo), 64'(0));

    // 2: fill 16, watermark, overflow
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 32'hA000_0000 + 32'(i), 0);
      if (i == 10) chk("t2_af_before", 64'(almost_full), 64'(0));
      if (i == 11) chk("t2_af_at12", 64'(almost_full), 64'(1));
    end
    chk("t2_full", 64'(fifo_full), 64'(1));
    chk("t2_head", 64'(data_from_fifo), 64'(32'hA000_0000));
    cycle(0, 0, 1, 32'hDEAD_DEAD, 0);
    chk("t2_ovf", 64'(overflow), 64'(1));
    chk("t2_level16", 64'(level), 64'(16));

    // 3: drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("t3_popdata", 64'(obs_dout), 64'(32'hA000_0000 + 32'(i)));
    end
    chk("t3_empty", 64'(fifo_empty), 64'(1));
    cycle(0, 0, 0, 0, 1);
    chk("t3_unf", 64'(underflow), 64'(1));
    chk("t3_rdptr", 64'(dut.rd_ptr_q), 64'(0));

    // 4: push+pop while full
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, $urandom, 0);
    cycle(0, 0, 1, 32'hBEEF_0001, 1);
    chk("t4_level", 64'(level), 64'(16));
    chk("t4_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1);
    chk("t4_last", 64'(obs_dout), 64'(32'hBEEF_0001));

    // 5: push+pop while empty -> no bypass
    cycle(0, 0, 1, 32'h1234_5678, 1);
    chk("t5_level", 64'(level), 64'(1));
    chk("t5_unf", 64'(underflow), 64'(1));
    chk("t5_dout", 64'(data_from_fifo), 64'(32'h1234_5678));

    // 6: wrap and flush
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 32'hC000_0000 + 32'(i), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 32'hD000_0000 + 32'(i), 0);
    chk("t6_wrptr", 64'(dut.wr_ptr_q), 64'(4));
    chk("t6_head", 64'(data_from_fifo), 64'(32'hD000_0000));
    cycle(0, 1, 1, 32'hFFFF_FFFF, 0);
    chk("t6_flush_level", 64'(level), 64'(0));
    chk("t6_flush_empty", 64'(fifo_empty), 64'(1));

    // Random traffic with varying producer/consumer balance, occasional flush and reset
    for (int blk = 0; blk < 8; blk++) begin
      pw = $urandom_range(90, 10);
      pr = $urandom_range(90, 10);
      for (int i = 0; i < 400; i++) begin
        cycle(($urandom_range(299) == 0), ($urandom_range(99) == 0),
              ($urandom_range(99) < pw), $urandom, ($urandom_range(99) < pr));
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
